tm1638_refresh_sched: RTL and testbench

TM1638_REFRESH_SCHED -- requirements
Module: tm1638_refresh_sched

---
 rtl/tm1638_refresh_sched_if.sv | 26 ++
 rtl/tm1638_refresh_sched.sv | 169 ++++++++++++++++
 tb/tb_tm1638_refresh_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_refresh_sched_if.sv
// Signal bundle between the refresh scheduler and whoever drives/observes it.
// The master side issues requests and reports engine idle; the slave is the scheduler.
interface tm1638_refresh_sched_if;
  logic        i_auto_en;
  logic        i_force_req;
  logic        i_bright_req;
  logic [2:0]  i_bright;
  logic        i_disp_on;
  logic        i_engine_idle;
  logic        o_refresh_en;
  logic        o_cmd_en;
  logic [7:0]  o_cmd;
  logic        o_busy;
  logic        o_fault;
  logic [15:0] o_refresh_count;

  modport master (
    output i_auto_en, i_force_req, i_bright_req, i_bright, i_disp_on, i_engine_idle,
    input  o_refresh_en, o_cmd_en, o_cmd, o_busy, o_fault, o_refresh_count
  );

  modport slave (
    input  i_auto_en, i_force_req, i_bright_req, i_bright, i_disp_on, i_engine_idle,
    output o_refresh_en, o_cmd_en, o_cmd, o_busy, o_fault, o_refresh_count
  );
endinterface

// File: rtl/tm1638_refresh_sched.sv
// Schedules periodic/forced TM1638 refreshes and display-control commands onto one engine.
// Optional completion watchdog: define TM1638_SCHED_WATCHDOG_EN.
module tm1638_refresh_sched #(
  parameter int CLOCK_FREQ_MHz = 12,
  parameter int REFRESH_HZ     = 50,
  parameter int WDOG_CYCLES    = 1_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  tm1638_refresh_sched_if.slave  io_sched
);

  localparam int TICKS = CLOCK_FREQ_MHz * 1_000_000 / REFRESH_HZ;
  localparam int TW    = $clog2(TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_GUARD, S_WAIT_DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic          r_pend_ref;
  logic          r_pend_cmd;
  logic [7:0]    r_cmd_byte;
  logic [7:0]    r_cmd;
  logic          r_job_cmd;
  logic          r_guard_last;
  logic          r_refresh_en;
  logic          r_cmd_en;
  logic          r_busy;
  logic [15:0]   r_refresh_count;

  logic w_tick_wrap;
  logic w_take_cmd;
  logic w_take_ref;
  logic w_wd_fire;

  assign w_tick_wrap = io_sched.i_auto_en && (r_tick == TICK_LAST);
  assign w_take_cmd  = (r_state == S_IDLE) && io_sched.i_engine_idle && r_pend_cmd;
  assign w_take_ref  = (r_state == S_IDLE) && io_sched.i_engine_idle && !r_pend_cmd && r_pend_ref;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
    end else if (!io_sched.i_auto_en || w_tick_wrap) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  // A new request in the same cycle its flag is consumed keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_ref <= 1'b0;
      r_pend_cmd <= 1'b0;
      r_cmd_byte <= 8'h88;
    end else begin
      r_pend_ref <= w_tick_wrap || io_sched.i_force_req || (r_pend_ref && !w_take_ref);
      r_pend_cmd <= io_sched.i_bright_req || (r_pend_cmd && !w_take_cmd);
      if (io_sched.i_bright_req) begin
        r_cmd_byte <= io_sched.i_disp_on ? (8'h88 | {5'b00000, io_sched.i_bright}) : 8'h80;
      end
    end
  end

`ifdef TM1638_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] r_wd;
  logic          r_fault;

  // r_wd equals cycles elapsed since LAUNCH; a done seen on the last cycle still wins.
  assign w_wd_fire = ((r_state == S_GUARD) ||
                      ((r_state == S_WAIT_DONE) && !io_sched.i_engine_idle)) &&
                     (r_wd == WD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wd <= WW'(1);
      end else if ((r_state == S_GUARD) || (r_state == S_WAIT_DONE)) begin
        r_wd <= r_wd + WW'(1);
      end
      if (w_wd_fire) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign io_sched.o_fault = r_fault;
`else
  wire w_unused_wdog = |WDOG_CYCLES;
  assign w_wd_fire        = 1'b0;
  assign io_sched.o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_cmd           <= 8'h00;
      r_job_cmd       <= 1'b0;
      r_guard_last    <= 1'b0;
      r_refresh_en    <= 1'b0;
      r_cmd_en        <= 1'b0;
      r_busy          <= 1'b0;
      r_refresh_count <= 16'h0000;
    end else begin
      r_refresh_en <= 1'b0;
      r_cmd_en     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_cmd) begin
            r_state   <= S_LAUNCH;
            r_busy    <= 1'b1;
            r_job_cmd <= 1'b1;
            r_cmd_en  <= 1'b1;
            r_cmd     <= r_cmd_byte;
          end else if (w_take_ref) begin
            r_state      <= S_LAUNCH;
            r_busy       <= 1'b1;
            r_job_cmd    <= 1'b0;
            r_refresh_en <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state      <= S_GUARD;
          r_guard_last <= 1'b0;
        end
        S_GUARD: begin
          if (w_wd_fire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_guard_last) begin
            r_state <= S_WAIT_DONE;
          end else begin
            r_guard_last <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (io_sched.i_engine_idle) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_job_cmd) begin
              r_refresh_count <= r_refresh_count + 16'd1;
            end
          end else if (w_wd_fire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_sched.o_refresh_en    = r_refresh_en;
  assign io_sched.o_cmd_en        = r_cmd_en;
  assign io_sched.o_cmd           = r_cmd;
  assign io_sched.o_busy          = r_busy;
  assign io_sched.o_refresh_count = r_refresh_count;

endmodule

// File: tb/tb_tm1638_refresh_sched.sv
// Bench for tm1638_refresh_sched: job-level reference model with a per-cycle compare,
// an engine that goes busy one cycle after each launch for 8 cycles, and directed scenarios.
module tb_tm1638_refresh_sched;

  localparam int WDOG = 50;

  logic clock = 1'b0;
  logic rstN  = 1'b1;

  tm1638_refresh_sched_if sched();

  tm1638_refresh_sched #(
    .CLOCK_FREQ_MHz(1),
    .REFRESH_HZ    (100000),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .i_clk   (clock),
    .i_rst_n (rstN),
    .io_sched(sched)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Downstream engine: busy for 8 cycles starting the cycle after a launch; can be held stuck.
  int engBusy;
  bit engStuck = 1'b0;
  always @(posedge clock or negedge rstN) begin
    if (!rstN) engBusy <= 0;
    else if (sched.o_refresh_en || sched.o_cmd_en) engBusy <= 8;
    else if (engBusy != 0) engBusy <= engBusy - 1;
  end
  assign sched.i_engine_idle = (engBusy == 0) && !engStuck;

  // Reference model: a job is described by its type and its age in cycles since launch.
  int         mPhase, mAge, mCount, mJob;
  bit         mPendRef, mPendCmd, mFault;
  logic [7:0] mByte, mCmdOut;
  int         nPhase, nAge, nCount, nJob;
  bit         nPendRef, nPendCmd, nFault, wrap, clrRef, clrCmd;
  logic [7:0] nByte, nCmdOut;

  always_comb begin
    wrap    = sched.i_auto_en && (mPhase == 9);
    nPhase  = sched.i_auto_en ? (mPhase + 1) % 10 : 0;
    clrRef  = 1'b0;
    clrCmd  = 1'b0;
    nJob    = mJob;
    nAge    = mAge + 1;
    nCount  = mCount;
    nFault  = mFault;
    nCmdOut = mCmdOut;
    if (mJob == 0) begin
      nAge = 0;
      if (sched.i_engine_idle && mPendCmd) begin
        nJob = 2; clrCmd = 1'b1; nCmdOut = mByte;
      end else if (sched.i_engine_idle && mPendRef) begin
        nJob = 1; clrRef = 1'b1;
      end
    end else if (mAge >= 3 && sched.i_engine_idle) begin
      nJob = 0;
      if (mJob == 1) nCount = (mCount + 1) % 65536;
    end
`ifdef TM1638_SCHED_WATCHDOG_EN
    else if (mAge >= WDOG - 1) begin
      nJob = 0; nFault = 1'b1;
    end
`endif
    nPendRef = (mPendRef && !clrRef) || wrap || sched.i_force_req;
    nPendCmd = (mPendCmd && !clrCmd) || sched.i_bright_req;
    nByte    = !sched.i_bright_req ? mByte :
               (sched.i_disp_on ? 8'h88 + 8'(sched.i_bright) : 8'h80);
  end

  always @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      mPhase <= 0; mAge <= 0; mCount <= 0; mJob <= 0;
      mPendRef <= 1'b0; mPendCmd <= 1'b0; mFault <= 1'b0;
      mByte <= 8'h88; mCmdOut <= 8'h00;
    end else begin
      mPhase <= nPhase; mAge <= nAge; mCount <= nCount; mJob <= nJob;
      mPendRef <= nPendRef; mPendCmd <= nPendCmd; mFault <= nFault;
      mByte <= nByte; mCmdOut <= nCmdOut;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      checkOutput("refresh_en", 32'(sched.o_refresh_en), 32'(mJob == 1 && mAge == 0));
      checkOutput("cmd_en", 32'(sched.o_cmd_en), 32'(mJob == 2 && mAge == 0));
      checkOutput("cmd", 32'(sched.o_cmd), 32'(mCmdOut));
      checkOutput("busy", 32'(sched.o_busy), 32'(mJob != 0));
      checkOutput("fault", 32'(sched.o_fault), 32'(mFault));
      checkOutput("refresh_count", 32'(sched.o_refresh_count), 32'(mCount));
    end
  end

  // Launch log: 256 marks a refresh, otherwise the command byte issued.
  int cycleNum = 0;
  int lastLaunchCycle = -1;
  int faultRiseCycle = -1;
  bit prevFault = 1'b0;
  int launchLog[$];

  initial begin
    forever begin
      @(negedge clock);
      cycleNum++;
      if (sched.o_refresh_en) begin
        launchLog.push_back(256);
        lastLaunchCycle = cycleNum;
      end
      if (sched.o_cmd_en) begin
        launchLog.push_back(int'(sched.o_cmd));
        lastLaunchCycle = cycleNum;
      end
      if (sched.o_fault && !prevFault) faultRiseCycle = cycleNum;
      prevFault = sched.o_fault;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input bit forceReq, input bit brightReq, input logic [2:0] bright, input bit dispOn);
    @(negedge clock);
    sched.i_force_req  = forceReq;
    sched.i_bright_req = brightReq;
    sched.i_bright     = bright;
    sched.i_disp_on    = dispOn;
    @(negedge clock);
    sched.i_force_req  = 1'b0;
    sched.i_bright_req = 1'b0;
  endtask

  task automatic waitRefreshLaunch(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (sched.o_refresh_en) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    sched.i_auto_en    = 1'b0;
    sched.i_force_req  = 1'b0;
    sched.i_bright_req = 1'b0;
    sched.i_bright     = 3'd0;
    sched.i_disp_on    = 1'b0;
    #1 rstN = 1'b0;
    waitCycles(3);
    checkOutput("reset_busy", 32'(sched.o_busy), 32'd0);
    checkOutput("reset_cmd", 32'(sched.o_cmd), 32'h00);
    checkOutput("reset_count", 32'(sched.o_refresh_count), 32'd0);
    rstN = 1'b1;
    waitCycles(2);

    $display("[TB] auto refresh");
    launchLog.delete();
    sched.i_auto_en = 1'b1;
    waitCycles(100);
    sched.i_auto_en = 1'b0;
    waitCycles(40);
    checkOutput("auto_pulses", 32'(launchLog.size()), 32'd10);
    checkOutput("auto_count", 32'(sched.o_refresh_count), 32'd10);
    checkOutput("model_auto_count", 32'(mCount), 32'd10);

    $display("[TB] priority");
    launchLog.delete();
    applyStimulus(1'b1, 1'b1, 3'd5, 1'b1);
    waitCycles(30);
    checkOutput("prio_jobs", 32'(launchLog.size()), 32'd2);
    if (launchLog.size() == 2) begin
      checkOutput("prio_first_cmd", 32'(launchLog[0]), 32'h8D);
      checkOutput("prio_second_ref", 32'(launchLog[1]), 32'd256);
    end
    checkOutput("prio_count", 32'(sched.o_refresh_count), 32'd11);

    $display("[TB] display off");
    launchLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
    waitCycles(15);
    checkOutput("off_jobs", 32'(launchLog.size()), 32'd1);
    checkOutput("off_cmd_held", 32'(sched.o_cmd), 32'h80);

    $display("[TB] coalescing");
    launchLog.delete();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    waitCycles(2);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
      waitCycles(1);
    end
    waitCycles(30);
    checkOutput("coalesce_jobs", 32'(launchLog.size()), 32'd2);
    checkOutput("coalesce_count", 32'(sched.o_refresh_count), 32'd13);

    $display("[TB] request during clear");
    launchLog.delete();
    @(negedge clock);
    sched.i_force_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    sched.i_force_req = 1'b0;
    waitCycles(30);
    checkOutput("setwins_jobs", 32'(launchLog.size()), 32'd2);
    checkOutput("setwins_count", 32'(sched.o_refresh_count), 32'd15);

    $display("[TB] command update in flight");
    launchLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b1);
    waitCycles(3);
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b1);
    waitCycles(30);
    checkOutput("inflight_jobs", 32'(launchLog.size()), 32'd2);
    if (launchLog.size() == 2) begin
      checkOutput("inflight_first", 32'(launchLog[0]), 32'h8B);
      checkOutput("inflight_second", 32'(launchLog[1]), 32'h89);
    end

    $display("[TB] stuck engine");
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    waitRefreshLaunch("wdog_launch_seen");
    engStuck = 1'b1;
    waitCycles(80);
`ifdef TM1638_SCHED_WATCHDOG_EN
    checkOutput("wdog_latency", 32'(faultRiseCycle - lastLaunchCycle), 32'd50);
    checkOutput("wdog_fault", 32'(sched.o_fault), 32'd1);
    checkOutput("wdog_idle", 32'(sched.o_busy), 32'd0);
    engStuck = 1'b0;
    waitCycles(15);
    checkOutput("wdog_count", 32'(sched.o_refresh_count), 32'd15);
    checkOutput("wdog_sticky", 32'(sched.o_fault), 32'd1);
`else
    checkOutput("nowdog_busy", 32'(sched.o_busy), 32'd1);
    checkOutput("nowdog_fault", 32'(sched.o_fault), 32'd0);
    engStuck = 1'b0;
    waitCycles(15);
    checkOutput("nowdog_count", 32'(sched.o_refresh_count), 32'd16);
`endif

    $display("[TB] reset mid-job");
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    waitRefreshLaunch("rst_launch_seen");
    waitCycles(5);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_refresh_en", 32'(sched.o_refresh_en), 32'd0);
    checkOutput("rst_cmd_en", 32'(sched.o_cmd_en), 32'd0);
    checkOutput("rst_busy", 32'(sched.o_busy), 32'd0);
    checkOutput("rst_fault", 32'(sched.o_fault), 32'd0);
    checkOutput("rst_count", 32'(sched.o_refresh_count), 32'd0);
    checkOutput("rst_cmd", 32'(sched.o_cmd), 32'h00);
    waitCycles(2);
    rstN = 1'b1;
    launchLog.delete();
    waitCycles(20);
    checkOutput("rst_no_launch", 32'(launchLog.size()), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    waitCycles(15);
    checkOutput("rst_resume_jobs", 32'(launchLog.size()), 32'd1);
    checkOutput("rst_resume_count", 32'(sched.o_refresh_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
